// File: rtl/cp0_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// cp0_access_arbiter_if
// Purpose : Bundles the requester handshakes, the mfc0 response and the CP0
//           register-file port that the CP0 access arbiter sits between.
// Modports:
//   slave  - arbiter side: takes the exc/alu/tlb requests and cp0_rdata,
//            drives the readies, the mfc0 response and the CP0 strobes.
//   master - requester/CP0 side: the mirror image of slave.
// Signals : exc_valid/exc_ready, alu_valid/alu_ready/alu_we/alu_addr/alu_sel/
//           alu_wdata, alu_rsp_valid/alu_rsp_data, tlb_valid/tlb_ready,
//           cp0_we/cp0_addr/cp0_sel/cp0_wdata/cp0_rdata, cp0_tlb_we, cp0_exc_en
// ---------------------------------------------------------------------------
interface cp0_access_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 3,
    parameter int DATA_W = 32
);
    logic              exc_valid;
    logic              exc_ready;
    logic              alu_valid;
    logic              alu_ready;
    logic              alu_we;
    logic [ADDR_W-1:0] alu_addr;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] alu_wdata;
    logic              alu_rsp_valid;
    logic [DATA_W-1:0] alu_rsp_data;
    logic              tlb_valid;
    logic              tlb_ready;
    logic              cp0_we;
    logic [ADDR_W-1:0] cp0_addr;
    logic [SEL_W-1:0]  cp0_sel;
    logic [DATA_W-1:0] cp0_wdata;
    logic [DATA_W-1:0] cp0_rdata;
    logic              cp0_tlb_we;
    logic              cp0_exc_en;

    modport slave (
        input  exc_valid, alu_valid, alu_we, alu_addr, alu_sel, alu_wdata,
               tlb_valid, cp0_rdata,
        output exc_ready, alu_ready, tlb_ready, alu_rsp_valid, alu_rsp_data,
               cp0_we, cp0_addr, cp0_sel, cp0_wdata, cp0_tlb_we, cp0_exc_en
    );

    modport master (
        output exc_valid, alu_valid, alu_we, alu_addr, alu_sel, alu_wdata,
               tlb_valid, cp0_rdata,
        input  exc_ready, alu_ready, tlb_ready, alu_rsp_valid, alu_rsp_data,
               cp0_we, cp0_addr, cp0_sel, cp0_wdata, cp0_tlb_we, cp0_exc_en
    );
endinterface

// File: rtl/cp0_access_arbiter.sv
// ---------------------------------------------------------------------------
// cp0_access_arbiter
// Purpose : Shares the single CP0 register-file port between exception
//           commit (highest priority), the TLB unit and ALU0 (mtc0/mfc0).
//           ALU and TLB are round-robin arbitrated. Every exception/ERET grant
//           opens a FLUSH window of FLUSH_CYC cycles that blocks ALU and TLB.
//           mfc0 read data comes back registered one cycle after the grant.
// Ports   :
//   clk  - clock, all state on posedge
//   rst  - asynchronous, active-low reset
//   bus  - cp0_access_arbiter_if.slave (requests, readies, response, CP0 port)
//   stat_exc/stat_alu/stat_tlb/stat_stall - 32-bit saturating grant/stall
//          counters, present only when CP0_ARB_STATS_EN is defined
// Config  : `define CP0_ARB_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module cp0_access_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int SEL_W     = 3,
    parameter int DATA_W    = 32,
    parameter int FLUSH_CYC = 3
) (
    input  logic                clk,
    input  logic                rst,
    cp0_access_arbiter_if.slave bus
`ifdef CP0_ARB_STATS_EN
    ,
    output logic [31:0]         stat_exc,
    output logic [31:0]         stat_alu,
    output logic [31:0]         stat_tlb,
    output logic [31:0]         stat_stall
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic RR_ALU = 1'b0;
    localparam logic RR_TLB = 1'b1;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYC - 1);

    if (FLUSH_CYC < 1 || FLUSH_CYC > 15) begin : g_bad_flush_cyc
        $error("cp0_access_arbiter: FLUSH_CYC=%0d outside 1..15", FLUSH_CYC);
    end

    logic [0:0]        r_state;
    logic [3:0]        r_flush_cnt;
    logic              r_rr_ptr;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;

    logic              w_exc_gnt;
    logic              w_alu_gnt;
    logic              w_tlb_gnt;
    logic              w_mfc0_gnt;

    // Grants look only at valids, state and reset so a requester may wait on
    // ready without forming a combinational loop. Holding reset low forces
    // every grant (and therefore every strobe) to 0.
    always_comb begin
        // NOTE: each signal gets a default before any branch so that no path
        // leaves it unassigned, which is what keeps a latch from being inferred.
        w_exc_gnt = 1'b0;
        w_alu_gnt = 1'b0;
        w_tlb_gnt = 1'b0;
        if (rst) begin
            if (bus.exc_valid) begin
                w_exc_gnt = 1'b1;
            end else if (r_state == ST_IDLE) begin
                // A lone requester wins; on contention rr_ptr picks.
                if (bus.alu_valid && (!bus.tlb_valid || r_rr_ptr == RR_ALU)) begin
                    w_alu_gnt = 1'b1;
                end else if (bus.tlb_valid) begin
                    w_tlb_gnt = 1'b1;
                end
            end
        end
    end

    assign w_mfc0_gnt = w_alu_gnt & ~bus.alu_we;

    assign bus.exc_ready  = w_exc_gnt;
    assign bus.alu_ready  = w_alu_gnt;
    assign bus.tlb_ready  = w_tlb_gnt;
    assign bus.cp0_exc_en = w_exc_gnt;
    assign bus.cp0_tlb_we = w_tlb_gnt;
    assign bus.cp0_we     = w_alu_gnt & bus.alu_we;

    // ALU payload passes straight to CP0; zeroed while reset is held so that
    // every output sits at 0 during reset.
    assign bus.cp0_addr  = rst ? bus.alu_addr  : {ADDR_W{1'b0}};
    assign bus.cp0_sel   = rst ? bus.alu_sel   : {SEL_W{1'b0}};
    assign bus.cp0_wdata = rst ? bus.alu_wdata : {DATA_W{1'b0}};

    assign bus.alu_rsp_valid = r_rsp_valid;
    assign bus.alu_rsp_data  = r_rsp_data;

    // FLUSH window control and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state is updated with non-blocking assignments so
            // every register samples pre-edge values regardless of block order.
            r_state     <= ST_IDLE;
            r_flush_cnt <= 4'd0;
            r_rr_ptr    <= RR_ALU;
        end else begin
            if (w_exc_gnt) begin
                // Exceptions and ERETs (re)open the window from either state.
                r_state     <= ST_FLUSH;
                r_flush_cnt <= FLUSH_RELOAD;
            end else if (r_state == ST_FLUSH) begin
                if (r_flush_cnt == 4'd0) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_flush_cnt <= r_flush_cnt - 4'd1;
                end
            end

            if (w_alu_gnt) begin
                r_rr_ptr <= RR_TLB;
            end else if (w_tlb_gnt) begin
                r_rr_ptr <= RR_ALU;
            end
        end
    end

    // mfc0 response: one-cycle valid pulse; data holds until the next mfc0.
    // CP0 writes on the same posedge, so an mfc0 right after an mtc0 to the
    // same register already sees the new value on cp0_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {DATA_W{1'b0}};
        end else begin
            r_rsp_valid <= w_mfc0_gnt;
            if (w_mfc0_gnt) begin
                r_rsp_data <= bus.cp0_rdata;
            end
        end
    end

`ifdef CP0_ARB_STATS_EN
    logic w_stall;

    // A cycle counts as a stall once, even if both ALU and TLB are waiting.
    assign w_stall = (bus.alu_valid & ~w_alu_gnt) | (bus.tlb_valid & ~w_tlb_gnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_exc   <= 32'd0;
            stat_alu   <= 32'd0;
            stat_tlb   <= 32'd0;
            stat_stall <= 32'd0;
        end else begin
            if (w_exc_gnt && stat_exc != 32'hFFFF_FFFF) begin
                stat_exc <= stat_exc + 32'd1;
            end
            if (w_alu_gnt && stat_alu != 32'hFFFF_FFFF) begin
                stat_alu <= stat_alu + 32'd1;
            end
            if (w_tlb_gnt && stat_tlb != 32'hFFFF_FFFF) begin
                stat_tlb <= stat_tlb + 32'd1;
            end
            if (w_stall && stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cp0_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cp0_access_arbiter
// Purpose : Self-checking bench for cp0_access_arbiter (FLUSH_CYC = 3).
//           A table of per-cycle request vectors with expected grants is
//           applied in order; mfc0 grants push the expected read data into a
//           scoreboard queue that is popped when the response is due. Two
//           hand-written sequences cover reset mid-FLUSH and mid-response.
//           A small CP0 register-file model supplies cp0_rdata and takes
//           cp0_we writes.
// ---------------------------------------------------------------------------
module tb_cp0_access_arbiter;

    logic clk;
    logic rst;
    logic model_load;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    cp0_access_arbiter_if #(.ADDR_W(5), .SEL_W(3), .DATA_W(32)) bus ();

`ifdef CP0_ARB_STATS_EN
    logic [31:0] stat_exc;
    logic [31:0] stat_alu;
    logic [31:0] stat_tlb;
    logic [31:0] stat_stall;
`endif

    cp0_access_arbiter #(
        .ADDR_W(5), .SEL_W(3), .DATA_W(32), .FLUSH_CYC(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef CP0_ARB_STATS_EN
        ,
        .stat_exc   (stat_exc),
        .stat_alu   (stat_alu),
        .stat_tlb   (stat_tlb),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CP0 register-file model: combinational read, write on posedge.
    logic [31:0] cp0_regs [32];

    assign bus.cp0_rdata = cp0_regs[bus.cp0_addr];

    always @(posedge clk) begin
        if (model_load) begin
            for (int i = 0; i < 32; i++) begin
                cp0_regs[i] <= (i == 12) ? 32'h0040_FF01 : (32'hC0DE_0000 | 32'(i));
            end
        end else if (bus.cp0_we) begin
            cp0_regs[bus.cp0_addr] <= bus.cp0_wdata;
        end
    end

    typedef struct packed {
        logic        ev;
        logic        av;
        logic        awe;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        tv;
        logic        er;
        logic        ar;
        logic        tr;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic ev, input logic av, input logic awe,
                                input logic [4:0] addr, input logic [31:0] wd,
                                input logic tv, input logic er, input logic ar,
                                input logic tr, input logic [31:0] rd);
        vec_t v;
        v.ev = ev; v.av = av; v.awe = awe; v.addr = addr; v.wd = wd; v.tv = tv;
        v.er = er; v.ar = ar; v.tr = tr; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.exc_valid = v.ev;
        bus.alu_valid = v.av;
        bus.alu_we    = v.awe;
        bus.alu_addr  = v.addr;
        bus.alu_sel   = 3'd0;
        bus.alu_wdata = v.wd;
        bus.tlb_valid = v.tv;
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, return at posedge+1.
    task automatic step(input vec_t v, input string tag);
        logic [31:0] d;
        drive(v);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            d = exp_q.pop_front();
            check({tag, " rsp_valid"}, 32'(bus.alu_rsp_valid), 32'd1);
            check({tag, " rsp_data"}, bus.alu_rsp_data, d);
        end else begin
            check({tag, " rsp_valid"}, 32'(bus.alu_rsp_valid), 32'd0);
        end
        check({tag, " grants{exc,alu,tlb}"},
              32'({bus.exc_ready, bus.alu_ready, bus.tlb_ready}),
              32'({v.er, v.ar, v.tr}));
        check({tag, " strobes{exc_en,tlb_we,we}"},
              32'({bus.cp0_exc_en, bus.cp0_tlb_we, bus.cp0_we}),
              32'({v.er, v.tr, v.ar & v.awe}));
        if (v.ar) begin
            check({tag, " cp0_addr"}, 32'(bus.cp0_addr), 32'(v.addr));
            check({tag, " cp0_wdata"}, bus.cp0_wdata, v.wd);
        end
        if (v.ar && !v.awe) begin
            exp_q.push_back(v.rd);
        end
        @(posedge clk);
        #1;
    endtask

    // Checks taken while reset is held low.
    task automatic check_in_reset(input string tag);
        check({tag, " grants{exc,alu,tlb}"},
              32'({bus.exc_ready, bus.alu_ready, bus.tlb_ready}), 32'd0);
        check({tag, " strobes{exc_en,tlb_we,we}"},
              32'({bus.cp0_exc_en, bus.cp0_tlb_we, bus.cp0_we}), 32'd0);
        check({tag, " rsp_valid"}, 32'(bus.alu_rsp_valid), 32'd0);
        check({tag, " rsp_data"}, bus.alu_rsp_data, 32'd0);
    endtask

    localparam int N_VEC = 35;
    vec_t tbl [N_VEC];
    vec_t v_zero;

    initial begin
        //            ev av we addr  wd            tv  er ar tr  rd
        v_zero   = mk(0, 0, 0, 5'd0,  32'h0,        0,  0, 0, 0, 32'h0);
        tbl[0]   = v_zero;
        tbl[1]   = mk(0, 1, 0, 5'd12, 32'h0,        0,  0, 1, 0, 32'h0040_FF01); // mfc0 reg 12
        tbl[2]   = v_zero;
        tbl[3]   = mk(0, 0, 0, 5'd0,  32'h0,        1,  0, 0, 1, 32'h0);         // lone TLB
        tbl[4]   = mk(0, 0, 0, 5'd0,  32'h0,        1,  0, 0, 1, 32'h0);         // lone TLB again
        tbl[5]   = mk(0, 1, 1, 5'd20, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'h0);         // mtc0 reg 20
        tbl[6]   = mk(0, 1, 0, 5'd20, 32'h0,        0,  0, 1, 0, 32'hDEAD_BEEF); // mfc0 reg 20 next cycle
        tbl[7]   = mk(0, 0, 0, 5'd0,  32'h0,        1,  0, 0, 1, 32'h0);         // rr -> ALU
        tbl[8]   = mk(0, 1, 0, 5'd3,  32'h0,        1,  0, 1, 0, 32'hC0DE_0003); // ALU
        tbl[9]   = mk(0, 1, 0, 5'd3,  32'h0,        1,  0, 0, 1, 32'h0);         // TLB
        tbl[10]  = mk(0, 1, 0, 5'd3,  32'h0,        1,  0, 1, 0, 32'hC0DE_0003); // ALU
        tbl[11]  = mk(0, 1, 0, 5'd3,  32'h0,        1,  0, 0, 1, 32'h0);         // TLB
        tbl[12]  = mk(1, 1, 0, 5'd3,  32'h0,        1,  1, 0, 0, 32'h0);         // all three: exc wins
        tbl[13]  = mk(0, 1, 0, 5'd3,  32'h0,        1,  0, 0, 0, 32'h0);         // flush 1
        tbl[14]  = mk(0, 1, 0, 5'd3,  32'h0,        1,  0, 0, 0, 32'h0);         // flush 2
        tbl[15]  = mk(0, 1, 0, 5'd3,  32'h0,        1,  0, 0, 0, 32'h0);         // flush 3
        tbl[16]  = mk(0, 1, 0, 5'd3,  32'h0,        1,  0, 1, 0, 32'hC0DE_0003); // ALU (rr=ALU)
        tbl[17]  = v_zero;
        tbl[18]  = mk(1, 0, 0, 5'd0,  32'h0,        0,  1, 0, 0, 32'h0);         // exc, cnt=2
        tbl[19]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 0, 0, 32'h0);         // cnt 2
        tbl[20]  = mk(1, 1, 0, 5'd3,  32'h0,        0,  1, 0, 0, 32'h0);         // exc at cnt=1, reload
        tbl[21]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 0, 0, 32'h0);
        tbl[22]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 0, 0, 32'h0);
        tbl[23]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 0, 0, 32'h0);
        tbl[24]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 1, 0, 32'hC0DE_0003);
        tbl[25]  = v_zero;
        tbl[26]  = mk(1, 0, 0, 5'd0,  32'h0,        0,  1, 0, 0, 32'h0);         // ERET-style grant
        tbl[27]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 0, 0, 32'h0);         // cnt 2
        tbl[28]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 0, 0, 32'h0);         // cnt 1
        tbl[29]  = mk(1, 1, 0, 5'd3,  32'h0,        0,  1, 0, 0, 32'h0);         // exc at cnt=0, reload
        tbl[30]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 0, 0, 32'h0);
        tbl[31]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 0, 0, 32'h0);
        tbl[32]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 0, 0, 32'h0);
        tbl[33]  = mk(0, 1, 0, 5'd3,  32'h0,        0,  0, 1, 0, 32'hC0DE_0003);
        tbl[34]  = v_zero;

        // Reset with all requests idle.
        rst        = 1'b0;
        model_load = 1'b1;
        drive(v_zero);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_in_reset("reset");
        @(posedge clk);
        #1;
        model_load = 1'b0;
        rst        = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // Reset pulsed mid-FLUSH; rr_ptr was left pointing at TLB.
        step(mk(1, 0, 0, 5'd0, 32'h0, 0, 1, 0, 0, 32'h0), "rstflush exc");
        step(mk(0, 1, 0, 5'd3, 32'h0, 1, 0, 0, 0, 32'h0), "rstflush blocked");
        rst = 1'b0;
        drive(mk(1, 1, 0, 5'd12, 32'h0, 1, 0, 0, 0, 32'h0));
        @(negedge clk);
        check_in_reset("rstflush held");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(mk(0, 1, 0, 5'd12, 32'h0, 1, 0, 1, 0, 32'h0040_FF01), "rstflush release");
        step(v_zero, "rstflush rsp");

        // Reset asserted while an mfc0 response is on the outputs.
        step(mk(0, 1, 0, 5'd5, 32'h0, 0, 0, 1, 0, 32'hC0DE_0005), "rstrsp grant");
        rst = 1'b0;
        drive(v_zero);
        #1;
        check_in_reset("rstrsp held");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(v_zero, "rstrsp after");

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
